// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch target buffer: 2-bit direction counter encoding and the
// per-entry record. Tags are held zero-padded to BP_TAG_W, so TAG_W must not exceed it.
package branch_predictor_pkg;

    localparam int BP_TAG_W = 8;

    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t STRONG_NT = 2'b00;
    localparam bp_ctr_t WEAK_NT   = 2'b01;
    localparam bp_ctr_t WEAK_T    = 2'b10;
    localparam bp_ctr_t STRONG_T  = 2'b11;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [31:0]         target;
        bp_ctr_t             ctr;
    } bp_entry_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-resolve signals between the pipeline (master) and the
// predictor (slave).
interface branch_predictor_if;

    logic [31:0] fetch_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_next_pc;

    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        inval_all;
    logic        mispredict;
    logic [31:0] redirect_pc;

    modport master (
        output fetch_pc, upd_en, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target, inval_all,
        input  pred_hit, pred_taken, pred_next_pc, mispredict, redirect_pc
    );

    modport slave (
        input  fetch_pc, upd_en, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target, inval_all,
        output pred_hit, pred_taken, pred_next_pc, mispredict, redirect_pc
    );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter: step toward the
// resolved outcome, holding at STRONG_T / STRONG_NT.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  bp_ctr_t ctr_i,
    input  logic    taken_i,
    output bp_ctr_t ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != STRONG_T) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != STRONG_NT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency lookup for fetch,
// resolve/update and mispredict redirect from execute. BP_STATS_EN adds branch counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int      ENTRIES  = 16,
    parameter int      TAG_W    = BP_TAG_W,
    parameter bp_ctr_t CTR_INIT = WEAK_NT
) (
    input  logic               CLK,
    input  logic               RST,
    branch_predictor_if.slave  bp
`ifdef BP_STATS_EN
    ,
    output logic [31:0]        stat_branches,
    output logic [31:0]        stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);

    bp_entry_t        ent_q [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    bp_entry_t        f_ent;

    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    bp_entry_t        u_ent;
    logic             u_hit;
    bp_ctr_t          u_ctr_nxt;

    logic             wr_en_d;
    bp_entry_t        wr_ent_d;

    logic             unused_pc_bits;

    // Lookup sees only registered state, so a same-cycle update is invisible until next cycle.
    assign f_idx = bp.fetch_pc[IDX_W+1:2];
    assign f_tag = bp.fetch_pc[IDX_W+2 +: TAG_W];
    assign f_ent = ent_q[f_idx];

    assign bp.pred_hit     = f_ent.valid && (f_ent.tag == BP_TAG_W'(f_tag));
    assign bp.pred_taken   = bp.pred_hit && f_ent.ctr[1];
    assign bp.pred_next_pc = bp.pred_taken ? f_ent.target : pc_plus4(bp.fetch_pc);

    assign bp.mispredict  = bp.upd_en &&
                            ((bp.upd_taken != bp.upd_pred_taken) ||
                             (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));
    assign bp.redirect_pc = bp.upd_taken ? bp.upd_target : pc_plus4(bp.upd_pc);

    assign u_idx = bp.upd_pc[IDX_W+1:2];
    assign u_tag = bp.upd_pc[IDX_W+2 +: TAG_W];
    assign u_ent = ent_q[u_idx];
    assign u_hit = u_ent.valid && (u_ent.tag == BP_TAG_W'(u_tag));

    sat_counter2 u_sat (
        .ctr_i   (u_ent.ctr),
        .taken_i (bp.upd_taken),
        .ctr_o   (u_ctr_nxt)
    );

    always_comb begin
        wr_en_d  = 1'b0;
        wr_ent_d = u_ent;
        if (bp.upd_en) begin
            if (u_hit) begin
                wr_en_d      = 1'b1;
                wr_ent_d.ctr = u_ctr_nxt;
                if (bp.upd_taken) wr_ent_d.target = bp.upd_target;
            end else if (bp.upd_taken) begin
                // A taken miss evicts whatever alias occupied this index.
                wr_en_d         = 1'b1;
                wr_ent_d.valid  = 1'b1;
                wr_ent_d.tag    = BP_TAG_W'(u_tag);
                wr_ent_d.target = bp.upd_target;
                wr_ent_d.ctr    = WEAK_T;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i].valid <= 1'b0;
                ent_q[i].ctr   <= CTR_INIT;
            end
        end else if (bp.inval_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i].valid <= 1'b0;
            end
        end else if (wr_en_d) begin
            ent_q[u_idx] <= wr_ent_d;
        end
    end

    assign unused_pc_bits = ^{bp.fetch_pc, bp.upd_pc};

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispredicts_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (bp.upd_en && (stat_branches_q != '1))
                stat_branches_q <= stat_branches_q + 32'd1;
            if (bp.mispredict && (stat_mispredicts_q != '1))
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised branch target buffer (BTB) with 2-bit saturating direction counters. It is the next-generation fetch-steering block for the pipelined datapath, which currently has no prediction and always fetches PC+4.
- Fetch stage looks up the current PC combinationally and receives a predicted next PC.
- Execute stage returns the resolved branch outcome. The block updates its table and flags a mispredict, together with the corrected PC that drives the flush and redirect.

Parameters:
ENTRIES, 16, number of BTB entries; power of 2, minimum 2.
TAG_W, 8, tag bits stored per entry; IDX_W+2+TAG_W must be at most 32.
CTR_INIT, 2'b01, counter value after reset (weakly not-taken).

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
fetch_pc  in  32  PC being fetched this cycle
pred_hit  out  1  valid entry whose tag matches fetch_pc
pred_taken  out  1  pred_hit AND counter[1]
pred_next_pc  out  32  pred_taken ? stored target : fetch_pc+4
upd_en  in  1  execute stage holds a resolved branch this cycle (caller gates with stall)
upd_pc  in  32  PC of the resolved branch
upd_taken  in  1  actual branch outcome
upd_target  in  32  actual branch target
upd_pred_taken  in  1  pred_taken carried down the pipe with this branch
upd_pred_target  in  32  pred_next_pc carried down the pipe with this branch
inval_all  in  1  clear every valid bit
mispredict  out  1  resolved branch disagrees with its prediction
redirect_pc  out  32  correct next PC when mispredict is high

Behaviour:
- Fields: IDX_W = log2(ENTRIES); idx = pc[IDX_W+1:2]; tag = pc[IDX_W+2 +: TAG_W]. Per entry: valid, tag, 32-bit target, 2-bit counter.
- Lookup: purely combinational, zero latency, so it can feed the PC mux in the same cycle that imemaddr is presented.
- Lookup during an update: lookup reads pre-update contents, with no write-to-read bypass, including when lookup and update hit the same index.
- Mispredict (combinational, qualified by upd_en): mispredict = upd_en AND (upd_taken != upd_pred_taken OR (upd_taken AND upd_target != upd_pred_target)).
- redirect_pc = upd_taken ? upd_target : upd_pc+4. redirect_pc is don't-care when mispredict is low but must still be driven.
- Update at a rising edge with upd_en=1 and the upd_pc entry a hit (valid and tag match):
  - counter saturating increment if taken, decrement if not taken; it never wraps past 2'b11 or 2'b00.
  - target overwritten with upd_target when taken.
- Update at a rising edge with upd_en=1 and a miss:
  - taken: allocate the entry, overwriting any prior occupant: valid=1, tag, target, counter=2'b10.
  - not taken: no change.
- Reset (RST=1 at an edge): all valid bits cleared, all counters set to CTR_INIT, targets and tags left undefined (no reset needed). Any upd_en in that cycle is ignored.
- After reset: pred_hit=0, pred_taken=0, pred_next_pc=fetch_pc+4, mispredict follows its equation.
- inval_all: clears all valid bits at the next edge; counters are left unchanged. It has priority over a simultaneous update, which is dropped.
- Arithmetic: all 32-bit, modulo 2^32, so fetch_pc=32'hFFFFFFFC gives pred_next_pc=0.
- Restriction: no unaligned PCs; bits [1:0] are ignored.

Optional Feature:
Macro BP_STATS_EN.
- Defined: adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches increments on each edge with upd_en=1.
  - stat_mispredicts increments on each edge with mispredict=1.
  - Both saturate at 32'hFFFFFFFF and clear to 0 on RST.
- Undefined: neither the ports nor the counters exist.

Decomposition:
- Shared package, in cpu_types_pkg or a new bp_pkg:
  - bp_ctr_t, a 2-bit typedef;
  - constants STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11;
  - bp_entry_t, a packed struct holding valid, tag, target and ctr, with the tag width set by a package-level default.
- One sub-module is natural: sat_counter2, a combinational next-state function (ctr, taken) -> ctr, instantiated at the update port.

Test Plan:
- Reset, then fetch_pc=32'h40 -> pred_hit=0, pred_taken=0, pred_next_pc=32'h44.
- Update upd_pc=32'h40, taken, target=32'h100, upd_pred_taken=0 -> same cycle mispredict=1, redirect_pc=32'h100. Next cycle fetch_pc=32'h40 -> pred_taken=1, pred_next_pc=32'h100 (counter 2'b10).
- Branch at 32'h40 resolved not-taken twice, with the correct pred_taken value each time -> first update gives mispredict=1 and redirect_pc=32'h44; counter reaches 2'b00. Three further not-taken updates keep it at 2'b00 (no wrap). Lookup gives pred_taken=0.
- Aliasing: with ENTRIES=16, 32'h40 and 32'h80 share idx 0 with different tags. 32'h80 allocated taken -> lookup 32'h40 gives pred_hit=0.
- Same-edge lookup and update of 32'h40: lookup that cycle shows old data; the new prediction appears the following cycle. inval_all asserted together with upd_en -> all entries miss afterwards and the update is dropped.
- With BP_STATS_EN defined, run 5 updates including 2 mispredicts -> stat_branches=5, stat_mispredicts=2. RST -> both read 0.
